// File: rtl/wb_bridge_pkg.sv
// wb_bridge_pkg: shared types and constants for the core-to-Wishbone bridge.
//   state_e   - bridge FSM states
//   SIZE_*    - core access size encodings (3 is illegal)
//   WDOG_W    - watchdog counter width (covers TIMEOUT_CYCLES up to 1023)
//   req_t     - request fields latched at acceptance that later stages still need
package wb_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUS     = 2'd1,
    ST_BACKOFF = 2'd2,
    ST_RESP    = 2'd3
  } state_e;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  localparam int WDOG_W    = 10;
  localparam int NUM_LANES = 4;

  typedef struct packed {
    logic [1:0] off;   // byte offset within the word
    logic [1:0] size;
    logic       we;
  } req_t;

  // Half must be 2-byte aligned, word 4-byte aligned, size 3 never legal.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SIZE_B:  return 1'b0;
      SIZE_H:  return off[0];
      SIZE_W:  return off != 2'd0;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/wb_lane_align.sv
// wb_lane_align: combinational byte-lane steering for a 32-bit Wishbone port.
//   off_i       in  2   byte offset (addr[1:0])
//   size_i      in  2   access size (SIZE_B/H/W)
//   wdata_i     in  32  LSB-justified store data
//   bus_rdata_i in  32  raw bus read data
//   sel_o       out 4   byte selects
//   wdata_o     out 32  store data replicated across lanes
//   rdata_o     out 32  load data shifted down and zero-extended
//   misalign_o  out 1   request is misaligned or has an illegal size
module wb_lane_align
  import wb_bridge_pkg::*;
(
  input  logic [1:0]  off_i,
  input  logic [1:0]  size_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] bus_rdata_i,
  output logic [3:0]  sel_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        misalign_o
);

  logic [NUM_LANES-1:0][7:0] wlane;
  logic [31:0]               shifted;

  // Replication means every lane already carries the right byte; sel picks it.
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    assign wlane[l] = (size_i == SIZE_B) ? wdata_i[7:0] :
                      (size_i == SIZE_H) ? wdata_i[8*(l%2) +: 8] :
                                           wdata_i[8*l +: 8];
  end

  assign wdata_o    = wlane;
  assign misalign_o = is_misaligned(size_i, off_i);
  assign shifted    = bus_rdata_i >> {off_i, 3'b000};

  always_comb begin
    sel_o   = 4'b1111;
    rdata_o = shifted;
    case (size_i)
      SIZE_B: begin
        sel_o   = 4'b0001 << off_i;
        rdata_o = {24'b0, shifted[7:0]};
      end
      SIZE_H: begin
        sel_o   = 4'b0011 << off_i;
        rdata_o = {16'b0, shifted[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/wb_core_bridge.sv
// wb_core_bridge: turns core LSU requests into single Wishbone classic cycles.
//   wb_clk_i / wb_rst_n_i         clock, async active-low reset
//   req_valid_i/req_ready_o       request handshake (ready only in IDLE)
//   req_addr_i/we_i/size_i/wdata_i request payload
//   rsp_valid_o/rsp_ready_i       response handshake
//   rsp_rdata_o/rsp_err_o         zero-extended load data, error flag
//   wb_io_*_o                     Wishbone master outputs (all registered)
//   wb_io_dat_i/ack_i/err_i/rty_i Wishbone slave returns
// Terminations: err > ack > rty. rty re-issues up to MAX_RETRY times via a
// one-cycle stb gap; a watchdog forces an error after TIMEOUT_CYCLES stb cycles.
module wb_core_bridge
  import wb_bridge_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int MAX_RETRY      = 3
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_addr_i,
  input  logic        req_we_i,
  input  logic [1:0]  req_size_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic [31:0] wb_io_adr_o,
  output logic [31:0] wb_io_dat_o,
  output logic [3:0]  wb_io_sel_o,
  output logic        wb_io_we_o,
  output logic        wb_io_cyc_o,
  output logic        wb_io_stb_o,
  input  logic [31:0] wb_io_dat_i,
  input  logic        wb_io_ack_i,
  input  logic        wb_io_err_i,
  input  logic        wb_io_rty_i
);

  localparam int                RTY_W     = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYCLES - 1);
  localparam logic [RTY_W-1:0]  RTY_MAX   = RTY_W'(MAX_RETRY);

  state_e             state_q;
  req_t               req_q;
  logic [WDOG_W-1:0]  wdog_q, wdog_d;
  logic [RTY_W-1:0]   rty_q, rty_d;
  logic               rdy_q, cyc_q, stb_q, we_q;
  logic [3:0]         sel_q;
  logic [31:0]        adr_q, dat_q;
  logic               rsp_valid_q, rsp_err_q;
  logic [31:0]        rsp_rdata_q;

  logic [1:0]  al_off, al_size;
  logic [3:0]  al_sel;
  logic [31:0] al_wdata, al_rdata;
  logic        al_misalign;
  logic        accept, rty_avail, wdog_hit;

  // In IDLE the aligner works on the live request (to register sel/dat at
  // acceptance); afterwards it uses the latched offset/size for read extraction.
  assign al_off  = (state_q == ST_IDLE) ? req_addr_i[1:0] : req_q.off;
  assign al_size = (state_q == ST_IDLE) ? req_size_i      : req_q.size;

  wb_lane_align u_align (
    .off_i       (al_off),
    .size_i      (al_size),
    .wdata_i     (req_wdata_i),
    .bus_rdata_i (wb_io_dat_i),
    .sel_o       (al_sel),
    .wdata_o     (al_wdata),
    .rdata_o     (al_rdata),
    .misalign_o  (al_misalign)
  );

  assign accept    = (state_q == ST_IDLE) & rdy_q & req_valid_i;
  assign rty_avail = rty_q < RTY_MAX;
  // wdog_q counts completed stb-high cycles minus one, so a hit here means
  // this edge closes the TIMEOUT_CYCLES-th stb cycle.
  assign wdog_hit  = wdog_q == WDOG_LAST;
  assign wdog_d    = wdog_q + 1'b1;
  assign rty_d     = rty_q + 1'b1;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q     <= ST_IDLE;
      req_q       <= '0;
      wdog_q      <= '0;
      rty_q       <= '0;
      rdy_q       <= 1'b0;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      adr_q       <= '0;
      dat_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          rdy_q <= 1'b1;
          if (accept) begin
            rdy_q      <= 1'b0;
            req_q.off  <= req_addr_i[1:0];
            req_q.size <= req_size_i;
            req_q.we   <= req_we_i;
            wdog_q     <= '0;
            rty_q      <= '0;
            if (al_misalign) begin
              state_q     <= ST_RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= '0;
            end else begin
              state_q <= ST_BUS;
              cyc_q   <= 1'b1;
              stb_q   <= 1'b1;
              we_q    <= req_we_i;
              sel_q   <= al_sel;
              adr_q   <= {req_addr_i[31:2], 2'b00};
              dat_q   <= al_wdata;
            end
          end
        end

        ST_BUS: begin
          if (wb_io_ack_i && !wb_io_err_i) begin
            state_q     <= ST_RESP;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= al_rdata;
          end else if (wb_io_rty_i && !wb_io_err_i && rty_avail) begin
            state_q <= ST_BACKOFF;
            stb_q   <= 1'b0;
            rty_q   <= rty_d;
          end else if (wb_io_err_i || wb_io_rty_i || wdog_hit) begin
            // bus error, retries exhausted, or watchdog
            state_q     <= ST_RESP;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_rdata_q <= '0;
          end else begin
            wdog_q <= wdog_d;
          end
        end

        ST_BACKOFF: begin
          state_q <= ST_BUS;
          stb_q   <= 1'b1;
          wdog_q  <= '0;
        end

        ST_RESP: begin
          if (rsp_ready_i) begin
            state_q     <= ST_IDLE;
            rdy_q       <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready_o = rdy_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_err_o   = rsp_err_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign wb_io_adr_o = adr_q;
  assign wb_io_dat_o = dat_q;
  assign wb_io_sel_o = sel_q;
  assign wb_io_we_o  = we_q;
  assign wb_io_cyc_o = cyc_q;
  assign wb_io_stb_o = stb_q;

endmodule

// File: tb/tb_wb_core_bridge.sv
module tb_wb_core_bridge;

  localparam int TO = 8;
  localparam int MR = 3;
  localparam int T_ACK = 0, T_ERR = 1, T_NONE = 2, T_AE = 3, T_AR = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0, bus_rd = '0;
  logic [1:0]  req_size = '0;
  logic        ack = 1'b0, err = 1'b0, rty = 1'b0;
  logic        req_ready, rsp_valid, rsp_err, we_o, cyc_o, stb_o;
  logic [31:0] rsp_rdata, adr_o, dat_o;
  logic [3:0]  sel_o;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  wb_core_bridge #(.TIMEOUT_CYCLES(TO), .MAX_RETRY(MR)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
    .req_we_i(req_we), .req_size_i(req_size), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .rsp_err_o(rsp_err),
    .wb_io_adr_o(adr_o), .wb_io_dat_o(dat_o), .wb_io_sel_o(sel_o), .wb_io_we_o(we_o),
    .wb_io_cyc_o(cyc_o), .wb_io_stb_o(stb_o), .wb_io_dat_i(bus_rd),
    .wb_io_ack_i(ack), .wb_io_err_i(err), .wb_io_rty_i(rty)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic m_misal(input logic [31:0] a, input logic [1:0] s);
    return (s == 2'd3) || (s == 2'd1 && a[0]) || (s == 2'd2 && a[1:0] != 2'd0);
  endfunction

  function automatic logic [3:0] m_sel(input logic [31:0] a, input logic [1:0] s);
    int o = int'(a[1:0]);
    if (s == 2'd0) return 4'(1 << o);
    if (s == 2'd1) return 4'(3 << o);
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wdat(input logic [31:0] wd, input logic [1:0] s);
    if (s == 2'd0) return 32'(wd[7:0]) * 32'h0101_0101;
    if (s == 2'd1) return 32'(wd[15:0]) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] m_rdat(input logic [31:0] rd, input logic [31:0] a, input logic [1:0] s);
    logic [31:0] v = rd >> (8 * int'(a[1:0]));
    if (s == 2'd0) return v & 32'hFF;
    if (s == 2'd1) return v & 32'hFFFF;
    return v;
  endfunction

  // One full transaction: the bench acts as slave, injecting nrty retries,
  // each after `waits` wait states, then the final termination `term`.
  task automatic run_txn(input logic [31:0] a, input logic w, input logic [1:0] s,
                         input logic [31:0] wd, input logic [31:0] rd,
                         input int nrty, input int waits, input int term);
    logic        mis, exhausted, exp_err;
    int          exp_stb, exp_bo, stb_n, bo_n, pw, rg, bnd, hold;
    logic [31:0] held;
    mis       = m_misal(a, s);
    exhausted = nrty > MR;
    exp_bo    = mis ? 0 : (exhausted ? MR : nrty);
    exp_stb   = mis ? 0 : ((exhausted ? MR + 1 : nrty) * (waits + 1) +
                           (exhausted ? 0 : (term == T_NONE ? TO : waits + 1)));
    exp_err   = mis || exhausted || term == T_ERR || term == T_AE || term == T_NONE;

    bnd = 0;
    while (!req_ready && bnd < 50) begin @(negedge clk); bnd++; end
    chk("req_ready_wait", 32'(req_ready), 32'd1);
    req_addr = a; req_we = w; req_size = s; req_wdata = wd; bus_rd = rd;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;

    stb_n = 0; bo_n = 0; pw = 0; rg = 0; bnd = 0;
    while (!rsp_valid && bnd < 200) begin
      ack = 1'b0; err = 1'b0; rty = 1'b0;
      if (cyc_o && stb_o) begin
        stb_n++;
        if (pw == 0) begin
          chk("adr", adr_o, {a[31:2], 2'b00});
          chk("sel", 32'(sel_o), 32'(m_sel(a, s)));
          chk("we", 32'(we_o), 32'(w));
          if (w) chk("dat_o", dat_o, m_wdat(wd, s));
        end
        if (pw < waits) pw++;
        else if (rg < nrty) begin rty = 1'b1; rg++; pw = 0; end
        else if (term == T_ACK) ack = 1'b1;
        else if (term == T_ERR) err = 1'b1;
        else if (term == T_AE) begin ack = 1'b1; err = 1'b1; end
        else if (term == T_AR) begin ack = 1'b1; rty = 1'b1; end
      end else if (cyc_o) begin
        bo_n++;
      end else begin
        chk("cyc_held", 32'(cyc_o), 32'd1);
        bnd = 200;
      end
      @(negedge clk);
      bnd++;
    end
    ack = 1'b0; err = 1'b0; rty = 1'b0;

    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("stb_cycles", 32'(stb_n), 32'(exp_stb));
    chk("backoffs", 32'(bo_n), 32'(exp_bo));
    chk("rsp_err", 32'(rsp_err), 32'(exp_err));
    chk("cyc_in_resp", 32'({cyc_o, stb_o}), 32'd0);
    chk("ready_in_resp", 32'(req_ready), 32'd0);
    if (mis) chk("rdata_misal", rsp_rdata, 32'd0);
    else if (!exp_err && !w) chk("rdata", rsp_rdata, m_rdat(rd, a, s));

    // Stall the response; stray terminations meanwhile must be ignored.
    held = rsp_rdata;
    hold = $urandom_range(1, 2);
    for (int i = 0; i < hold; i++) begin
      ack = 1'($urandom_range(0, 1)); err = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("rsp_hold", {29'd0, rsp_valid, rsp_err, cyc_o}, {29'd0, 1'b1, exp_err, 1'b0});
      chk("rdata_hold", rsp_rdata, held);
    end
    ack = 1'b0; err = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_drop", 32'(rsp_valid), 32'd0);
    chk("ready_after", 32'(req_ready), 32'd1);
  endtask

  initial begin
    #12;
    chk("rst_ctrl", {22'd0, cyc_o, stb_o, we_o, sel_o, rsp_valid, rsp_err, req_ready}, 32'd0);
    chk("rst_adr", adr_o, 32'd0);
    chk("rst_dat", dat_o, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    #1 chk("ready_pre_edge", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("ready_first_edge", 32'(req_ready), 32'd1);

    run_txn(32'h8004_0004, 1'b0, 2'd2, 32'h0, 32'hDEAD_BEEF, 0, 2, T_ACK);
    run_txn(32'h2000_0003, 1'b1, 2'd0, 32'h5A, 32'h0, 0, 0, T_ACK);
    run_txn(32'h2000_0012, 1'b0, 2'd1, 32'h0, 32'h1234_5678, 0, 0, T_ACK);
    run_txn(32'h2000_0102, 1'b0, 2'd2, 32'h0, 32'h0, 0, 0, T_ACK);
    run_txn(32'h1000_0000, 1'b0, 2'd2, 32'h0, 32'hCAFE_F00D, 3, 0, T_ACK);
    run_txn(32'h1000_0004, 1'b1, 2'd2, 32'h1111_2222, 32'h0, 4, 1, T_ACK);
    run_txn(32'h3000_0000, 1'b0, 2'd2, 32'h0, 32'h0, 0, 0, T_NONE);
    run_txn(32'h3000_0008, 1'b0, 2'd1, 32'h0, 32'hA5A5_5A5A, 0, 1, T_AE);
    run_txn(32'h3000_0009, 1'b0, 2'd0, 32'h0, 32'hA5A5_5A5A, 0, 1, T_AR);
    run_txn(32'h3000_000C, 1'b1, 2'd3, 32'h0, 32'h0, 0, 0, T_ACK);

    for (int n = 0; n < 80; n++) begin
      int r, t;
      r = int'($urandom_range(0, 9));
      t = (r < 6) ? T_ACK : (r == 6) ? T_ERR : (r == 7) ? T_AE : (r == 8) ? T_AR : T_NONE;
      run_txn($urandom, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, $urandom,
              int'($urandom_range(0, 4)), int'($urandom_range(0, 3)), t);
    end

    // Reset while a cycle is outstanding.
    req_addr = 32'h4000_0000; req_size = 2'd2; req_we = 1'b0; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    chk("mid_cyc_before", 32'({cyc_o, stb_o}), 32'd3);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("mid_rst_bus", {29'd0, cyc_o, stb_o, rsp_valid}, 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    #1 chk("mid_ready_pre", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("mid_ready_post", 32'(req_ready), 32'd1);
    chk("mid_no_rsp", 32'({rsp_valid, cyc_o}), 32'd0);
    run_txn(32'h4000_0006, 1'b0, 2'd1, 32'h0, 32'h8765_4321, 1, 0, T_ACK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
